// File: rtl/ram_loader.sv
// Streams DEPTH bytes from a valid/ready source into the program RAM's manual port,
// giving each write strobe a full cycle of address/data setup and hold, then checks an optional checksum.
module ram_loader #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter bit CHECKSUM = 1'b1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] addr_out,
    output logic [7:0]        data_out,
    output logic              load_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, RECV, SETUP, WRITE, HOLD, CHK, DONE, ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [7:0]        sum, sum_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        data_nx;
    logic [7:0]        chk_total;
    logic              accept;

    // in_ready is a registered state decode, so accept has no input-to-output path
    assign accept    = in_ready & in_valid;
    assign chk_total = sum + in_data;

    always_comb begin
        state_nx = state;
        sum_nx   = sum;
        addr_nx  = addr_out;
        data_nx  = data_out;
        if (abort && busy) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start && !abort) begin
                        state_nx = RECV;
                        sum_nx   = 8'h00;
                        addr_nx  = '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        data_nx  = in_data;
                        sum_nx   = chk_total;
                        state_nx = SETUP;
                    end
                end
                SETUP: state_nx = WRITE;
                WRITE: state_nx = HOLD;
                HOLD: begin
                    if (addr_out == LAST_ADDR) begin
                        state_nx = CHECKSUM ? CHK : DONE;
                    end else begin
                        addr_nx  = addr_out + 1'b1;
                        state_nx = RECV;
                    end
                end
                CHK: begin
                    if (accept) begin
                        state_nx = (chk_total == 8'h00) ? DONE : ERR;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            sum       <= 8'h00;
            addr_out  <= '0;
            data_out  <= 8'h00;
            in_ready  <= 1'b0;
            prog_mode <= 1'b0;
            load_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            sum       <= sum_nx;
            addr_out  <= addr_nx;
            data_out  <= data_nx;
            in_ready  <= (state_nx == RECV) || (state_nx == CHK);
            prog_mode <= state_nx inside {RECV, SETUP, WRITE, HOLD, CHK};
            load_out  <= (state_nx == WRITE);
            busy      <= state_nx inside {RECV, SETUP, WRITE, HOLD, CHK};
            done      <= (state_nx == DONE);
            err       <= (state_nx == ERR);
        end
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Program loader that fills the 16x8 program RAM before a run. It accepts a byte stream over a valid/ready handshake and writes bytes to consecutive RAM addresses starting at 0. It then checks an optional trailing checksum byte. It sits directly upstream of the RAM's manual-programming port and drives `program_mode`, `addr_in_manual`, `data_in_manual` and `load_manual` for the whole load sequence.

## Interface
- `DEPTH`, 16: number of bytes written per load; addresses run 0..DEPTH-1.
- `ADDR_W`, 4: address width; must satisfy 2^ADDR_W >= DEPTH.
- `CHECKSUM`, 1: 1 = one checksum byte follows the data bytes; 0 = no checksum byte.
- `clk` input 1: single clock; all state changes on the rising edge.
- `clr_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begins a load when sampled high in IDLE.
- `abort` input 1: cancels any load in progress.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `prog_mode` output 1: drives the RAM's `program_mode` input.
- `addr_out` output ADDR_W: drives the RAM's `addr_in_manual` input.
- `data_out` output 8: drives the RAM's `data_in_manual` input.
- `load_out` output 1: drives the RAM's `load_manual` input (write strobe).
- `busy` output 1: high in every state except IDLE, DONE and ERR.
- `done` output 1: load completed and checksum passed.
- `err` output 1: checksum mismatch.

## Operation
- States: IDLE, RECV, SETUP, WRITE, HOLD, CHK, DONE, ERR.
- IDLE
  - On `start`=1: clear address counter and running sum, clear `done`/`err`, go to RECV.
- RECV
  - `in_ready`=1.
  - A byte is accepted on a cycle where `in_valid`&`in_ready`=1. Latch it into `data_out`, add it to the 8-bit running sum (mod 256), go to SETUP.
  - With no valid byte, stay in RECV indefinitely; there is no timeout.
- SETUP: `load_out`=0. `addr_out` and `data_out` are stable. Go to WRITE.
- WRITE: `load_out`=1 for exactly one cycle. Go to HOLD.
- HOLD
  - `load_out`=0, with address and data still held.
  - If address = DEPTH-1: go to CHK when CHECKSUM=1, or to DONE when CHECKSUM=0.
  - Otherwise increment address, go to RECV.
- CHK
  - `in_ready`=1.
  - On an accepted byte: if (sum + byte) mod 256 == 0, go to DONE; otherwise go to ERR.
  - The checksum byte is never written to RAM.
- DONE / ERR
  - `done`=1 in DONE; `err`=1 in ERR. Both are sticky.
  - `prog_mode`=0.
  - A new `start` behaves exactly as in IDLE.
- `prog_mode`=1 in RECV, SETUP, WRITE, HOLD and CHK; 0 otherwise.
- `start` while `busy` is ignored.
- `abort` has priority over all other inputs. When sampled high in any busy state:
  - go to IDLE next edge, with `load_out`=0 and `prog_mode`=0;
  - `done`/`err` stay 0;
  - bytes already written to RAM remain.
- `in_ready`=0 outside RECV and CHK. No byte is ever dropped or double-accepted.

## Timing
- Reset values: state IDLE; `in_ready`, `prog_mode`, `load_out`, `busy`, `done`, `err` = 0; `addr_out`=0; `data_out`=0.
- Reset asserted mid-load forces these values immediately, without waiting for a clock edge. The RAM write strobe therefore drops at once.
- All outputs are registered. `in_ready` and `load_out` are state-decoded from registers and carry no combinational path from inputs.
- Per-byte cost is 4 cycles minimum: accept edge, SETUP, WRITE, HOLD.
- Address/data setup and hold around `load_out` are one full cycle each. This is required because the RAM writes level-sensitively while its load input is high.
- Full load with back-to-back `in_valid`, CHECKSUM=1: 4*DEPTH + 1 cycles from the first accept to entering DONE/ERR (65 for DEPTH=16).
- `start` → `in_ready`=1 one cycle later.
- Address counter never wraps: it stops at DEPTH-1.

## Test plan
- Reset, then `start`, then stream 0x00..0x0F plus checksum 0x88 (sum 0x78 + 0x88 = 0x100) → 16 `load_out` pulses at addresses 0..15 with data equal to the address, then `done`=1, `err`=0, `prog_mode`=0, and RAM contents match.
- Same stream with checksum 0x87 → all 16 writes still occur, `err`=1, `done`=0.
- `in_valid` toggled randomly with gaps → `addr_out`/`data_out` never change while `load_out`=1 or in the adjacent SETUP/HOLD cycles, and exactly 16 writes occur.
- `abort` asserted in WRITE at address 5 → next edge IDLE, `load_out`=0, `prog_mode`=0, addresses 0..5 written, address 6 untouched.
- `clr_n` pulled low mid-WRITE between edges → `load_out` and `prog_mode` drop immediately, all outputs at reset values.
- CHECKSUM=0, DEPTH=4: stream 0xA1, 0xB2, 0xC3, 0xD4 → `done`=1 exactly 16 cycles after the first accept; `start` pulsed while busy has no effect.
